vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 16 +
 rtl/vram_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared types and defaults for the VRAM arbiter
package vram_arb_pkg;

  // Arbiter states: idle, two video word fetches, one CPU byte access, CPU hand-off
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VID1 = 3'd1,
    VID2 = 3'd2,
    CPU  = 3'd3,
    DONE = 3'd4
  } arb_state_t;

  localparam logic [7:0] TIMEOUT_DEFAULT  = 8'd32;
  localparam logic [2:0] CPU_SLOT_DEFAULT = 3'd5;

endpackage

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - video/CPU arbiter for a 16-bit VRAM port; build option VRAM_ARB_CONTENTION_EN limits CPU starts to hc_phase == CPU_SLOT
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter logic [2:0] CPU_SLOT = CPU_SLOT_DEFAULT,
  parameter logic [7:0] TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_6mn,
  input  logic [2:0]  hc_phase,
  input  logic        vid_req,
  input  logic [18:0] vid_addr1,
  input  logic [18:0] vid_addr2,
  output logic [15:0] vid_dout1,
  output logic [15:0] vid_dout2,
  output logic        vid_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        cpu_wait,
  output logic        mem_req,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [1:0]  mem_be,
  output logic [15:0] mem_din,
  input  logic        mem_ack,
  input  logic [15:0] mem_dout,
  output logic        err_timeout
);

`ifdef VRAM_ARB_CONTENTION_EN
  localparam bit CONTENTION_EN = 1'b1;
`else
  localparam bit CONTENTION_EN = 1'b0;
`endif

  arb_state_t  state, state_next;
  logic [7:0]  watchdog, watchdog_next;

  logic        mem_req_next;
  logic        mem_we_next;
  logic [18:0] mem_addr_next;
  logic [1:0]  mem_be_next;
  logic [15:0] mem_din_next;
  logic [15:0] vid_dout1_next;
  logic [15:0] vid_dout2_next;
  logic        vid_valid_next;
  logic [7:0]  cpu_dout_next;
  logic        cpu_ack_next;
  logic        err_timeout_next;

  logic        slot_ok;
  logic        wd_expire;
  logic        grant_done;

  // With contention the CPU may only start in its own pixel phase; otherwise any ce_6mn will do
  assign slot_ok    = ~CONTENTION_EN | (hc_phase == CPU_SLOT);
  // Last idle-waiting cycle of an access; the watchdog reaches TIMEOUT at the coming edge
  assign wd_expire  = (watchdog == TIMEOUT - 8'd1);
  assign grant_done = (state == DONE);
  assign cpu_wait   = cpu_req & ~cpu_ack & ~grant_done;

  // State and all registered outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= IDLE;
      watchdog    <= 8'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 19'd0;
      mem_be      <= 2'b00;
      mem_din     <= 16'd0;
      vid_dout1   <= 16'd0;
      vid_dout2   <= 16'd0;
      vid_valid   <= 1'b0;
      cpu_dout    <= 8'd0;
      cpu_ack     <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      watchdog    <= watchdog_next;
      mem_req     <= mem_req_next;
      mem_we      <= mem_we_next;
      mem_addr    <= mem_addr_next;
      mem_be      <= mem_be_next;
      mem_din     <= mem_din_next;
      vid_dout1   <= vid_dout1_next;
      vid_dout2   <= vid_dout2_next;
      vid_valid   <= vid_valid_next;
      cpu_dout    <= cpu_dout_next;
      cpu_ack     <= cpu_ack_next;
      err_timeout <= err_timeout_next;
    end
  end

  // Slot decisions, memory port setup, data capture and watchdog abort
  always_comb begin
    state_next       = state;
    watchdog_next    = watchdog;
    mem_req_next     = mem_req;
    mem_we_next      = mem_we;
    mem_addr_next    = mem_addr;
    mem_be_next      = mem_be;
    mem_din_next     = mem_din;
    vid_dout1_next   = vid_dout1;
    vid_dout2_next   = vid_dout2;
    vid_valid_next   = 1'b0;
    cpu_dout_next    = cpu_dout;
    cpu_ack_next     = 1'b0;
    err_timeout_next = err_timeout;

    case (state)
      IDLE: begin
        watchdog_next = 8'd0;
        // Video wins any tie; a late mem_ack here is simply not looked at
        if (ce_6mn && vid_req) begin
          state_next    = VID1;
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = vid_addr1;
          mem_be_next   = 2'b11;
        end else if (ce_6mn && cpu_req && slot_ok) begin
          state_next    = CPU;
          mem_req_next  = 1'b1;
          mem_we_next   = cpu_we;
          mem_addr_next = cpu_addr[19:1];
          mem_be_next   = cpu_addr[0] ? 2'b10 : 2'b01;
          mem_din_next  = {cpu_din, cpu_din};
        end
      end

      VID1: begin
        if (mem_ack) begin
          // mem_req stays up; the second word is a fresh access with its own watchdog budget
          vid_dout1_next = mem_dout;
          mem_addr_next  = vid_addr2;
          watchdog_next  = 8'd0;
          state_next     = VID2;
        end else if (wd_expire) begin
          mem_req_next     = 1'b0;
          err_timeout_next = 1'b1;
          watchdog_next    = 8'd0;
          state_next       = IDLE;
        end else begin
          watchdog_next = watchdog + 8'd1;
        end
      end

      VID2: begin
        if (mem_ack) begin
          vid_dout2_next = mem_dout;
          vid_valid_next = 1'b1;
          mem_req_next   = 1'b0;
          watchdog_next  = 8'd0;
          state_next     = IDLE;
        end else if (wd_expire) begin
          mem_req_next     = 1'b0;
          err_timeout_next = 1'b1;
          watchdog_next    = 8'd0;
          state_next       = IDLE;
        end else begin
          watchdog_next = watchdog + 8'd1;
        end
      end

      CPU: begin
        if (mem_ack) begin
          // The latched byte lane selects which half of the word the CPU gets back
          cpu_dout_next = mem_be[1] ? mem_dout[15:8] : mem_dout[7:0];
          cpu_ack_next  = 1'b1;
          mem_req_next  = 1'b0;
          mem_we_next   = 1'b0;
          watchdog_next = 8'd0;
          state_next    = DONE;
        end else if (wd_expire) begin
          // The CPU still gets its ack so it never stalls forever; 8'hFF marks the dead read
          cpu_dout_next    = 8'hFF;
          cpu_ack_next     = 1'b1;
          mem_req_next     = 1'b0;
          mem_we_next      = 1'b0;
          err_timeout_next = 1'b1;
          watchdog_next    = 8'd0;
          state_next       = IDLE;
        end else begin
          watchdog_next = watchdog + 8'd1;
        end
      end

      DONE: begin
        // Hold here until the CPU lets go so one request is never served twice
        if (!cpu_req) begin
          state_next = IDLE;
        end
      end

      default: begin
        mem_req_next  = 1'b0;
        mem_we_next   = 1'b0;
        watchdog_next = 8'd0;
        state_next    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized scoreboard bench for vram_arbiter
module tb_vram_arbiter;

  localparam int         TIMEOUT_CYC = 32;
  localparam logic [2:0] SLOT        = 3'd5;
`ifdef VRAM_ARB_CONTENTION_EN
  localparam bit CONTENTION = 1'b1;
`else
  localparam bit CONTENTION = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ce_6mn;
  logic [2:0]  hc_phase;
  logic        vid_req;
  logic [18:0] vid_addr1, vid_addr2;
  logic [15:0] vid_dout1, vid_dout2;
  logic        vid_valid;
  logic        cpu_req, cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack, cpu_wait;
  logic        mem_req, mem_we;
  logic [18:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_din;
  logic        mem_ack;
  logic [15:0] mem_dout;
  logic        err_timeout;

  vram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset), .ce_6mn(ce_6mn), .hc_phase(hc_phase),
    .vid_req(vid_req), .vid_addr1(vid_addr1), .vid_addr2(vid_addr2),
    .vid_dout1(vid_dout1), .vid_dout2(vid_dout2), .vid_valid(vid_valid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_din(mem_din), .mem_ack(mem_ack), .mem_dout(mem_dout),
    .err_timeout(err_timeout)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected or not seen", name);
  endtask

  // Memory contents: environment copy (written by the memory responder) and reference copy
  logic [15:0] mem_arr [int];
  logic [15:0] ref_arr [int];

  function automatic logic [15:0] init_word(input int a);
    logic [31:0] t;
    t = a * 32'h9e37 + 32'h1234;
    return t[15:0] ^ t[31:16];
  endfunction

  function automatic logic [15:0] mem_rd(input int a);
    return mem_arr.exists(a) ? mem_arr[a] : init_word(a);
  endfunction

  function automatic logic [15:0] ref_rd(input int a);
    return ref_arr.exists(a) ? ref_arr[a] : init_word(a);
  endfunction

  // Expected traffic
  typedef struct {logic [18:0] addr; logic we; logic [1:0] be; logic [15:0] din; bit is_cpu;} acc_t;
  typedef struct {logic [15:0] d1; logic [15:0] d2;} vid_t;
  typedef struct {logic [7:0] d; bit chk;} cpu_t;
  acc_t acc_q[$];
  vid_t vid_q[$];
  cpu_t cpu_q[$];

  function automatic void push_acc(input logic [18:0] a, input logic we, input logic [1:0] be,
                                   input logic [15:0] din, input bit is_cpu);
    acc_t e;
    e.addr = a; e.we = we; e.be = be; e.din = din; e.is_cpu = is_cpu;
    acc_q.push_back(e);
  endfunction

  // Pixel clock enable every other cycle, phase advancing once per enable
  logic [31:0] tick = 0;
  initial begin
    ce_6mn = 1'b0;
    hc_phase = 3'd0;
    forever begin
      @(posedge clk_sys); #1;
      tick = tick + 1;
      ce_6mn = tick[0];
      hc_phase = tick[3:1];
    end
  end

  // Memory responder: acks lat cycles after a request is seen, one-cycle ack
  int          lat = 2;
  int          cnt = 0;
  bit          block_en = 0;
  logic [18:0] block_addr = '0;
  bit          force_ack = 0;
  initial begin
    logic [15:0] w;
    mem_ack = 1'b0;
    mem_dout = 16'd0;
    forever begin
      @(posedge clk_sys); #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        cnt = 0;
      end else if (force_ack) begin
        mem_ack = 1'b1;
        mem_dout = 16'hDEAD;
        force_ack = 0;
      end else if (mem_req && !(block_en && mem_addr == block_addr)) begin
        if (cnt >= lat) begin
          w = mem_rd(int'(mem_addr));
          if (mem_we) begin
            if (mem_be[0]) w[7:0]  = mem_din[7:0];
            if (mem_be[1]) w[15:8] = mem_din[15:8];
            mem_arr[int'(mem_addr)] = w;
          end
          mem_dout = w;
          mem_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: compares every DUT presentation against the queues
  bit         prev_req = 0, prev_ce = 0;
  logic [2:0] prev_hc = 0;
  bit         vid_seen = 0, order_chk = 0, cpu_acked = 0;
  int         run_len = 0, last_len = 0;
  initial begin
    acc_t e; vid_t v; cpu_t c;
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (mem_req && !prev_req) begin
          chk("start_on_ce", {31'd0, prev_ce}, 32'd1);
          if (CONTENTION && acc_q.size() > 0 && acc_q[0].is_cpu)
            chk("cpu_start_phase", {29'd0, prev_hc}, {29'd0, SLOT});
        end
        if (mem_req && mem_ack) begin
          if (acc_q.size() == 0) fail_now("unexpected_mem_access");
          else begin
            e = acc_q.pop_front();
            chk("mem_addr", {13'd0, mem_addr}, {13'd0, e.addr});
            chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
            chk("mem_be", {30'd0, mem_be}, {30'd0, e.be});
            if (e.we) chk("mem_din", {16'd0, mem_din}, {16'd0, e.din});
          end
        end
        if (vid_valid) begin
          if (vid_q.size() == 0) fail_now("unexpected_vid_valid");
          else begin
            v = vid_q.pop_front();
            chk("vid_dout1", {16'd0, vid_dout1}, {16'd0, v.d1});
            chk("vid_dout2", {16'd0, vid_dout2}, {16'd0, v.d2});
          end
          vid_seen = 1;
        end
        if (cpu_ack) begin
          if (cpu_q.size() == 0) fail_now("unexpected_cpu_ack");
          else begin
            c = cpu_q.pop_front();
            if (c.chk) chk("cpu_dout", {24'd0, cpu_dout}, {24'd0, c.d});
          end
          if (order_chk) chk("cpu_after_vid", {31'd0, vid_seen}, 32'd1);
          cpu_acked = 1;
        end
        if (cpu_req && !cpu_ack && !cpu_acked) chk("cpu_wait", {31'd0, cpu_wait}, 32'd1);
        if (!cpu_req) cpu_acked = 0;
        if (mem_req) run_len++;
        else if (prev_req) begin
          last_len = run_len;
          run_len = 0;
        end
      end
      prev_req = mem_req;
      prev_ce = ce_6mn;
      prev_hc = hc_phase;
    end
  end

  // One transaction group: expectations from the reference model, then drive until served
  task automatic do_txn(input bit dv, input bit dc, input logic [18:0] a1, input logic [18:0] a2,
                        input logic [19:0] ca, input bit we, input logic [7:0] din, input bit expect_to);
    logic [15:0] w;
    bit vpend, cpend;
    int n;
    cpu_t c;
    vid_t v;
    if (dv) begin
      push_acc(a1, 1'b0, 2'b11, 16'd0, 0);
      push_acc(a2, 1'b0, 2'b11, 16'd0, 0);
      v.d1 = ref_rd(int'(a1));
      v.d2 = ref_rd(int'(a2));
      vid_q.push_back(v);
    end
    if (dc) begin
      w = ref_rd(int'(ca[19:1]));
      if (expect_to) begin
        c.d = 8'hFF; c.chk = 1;
      end else begin
        push_acc(ca[19:1], we, ca[0] ? 2'b10 : 2'b01, {din, din}, 1);
        c.d = ca[0] ? w[15:8] : w[7:0];
        c.chk = !we;
        if (we) begin
          if (ca[0]) w[15:8] = din; else w[7:0] = din;
          ref_arr[int'(ca[19:1])] = w;
        end
      end
      cpu_q.push_back(c);
    end
    vid_seen = 0;
    order_chk = dv && dc;
    vid_addr1 = a1; vid_addr2 = a2; vid_req = dv;
    cpu_addr = ca; cpu_we = we; cpu_din = din; cpu_req = dc;
    vpend = dv; cpend = dc; n = 0;
    while ((vpend || cpend) && n < 3000) begin
      @(posedge clk_sys); #1;
      n++;
      if (vid_valid) begin vid_req = 0; vpend = 0; end
      if (cpu_ack)   begin cpu_req = 0; cpend = 0; end
    end
    if (vpend || cpend) begin
      fail_now("txn_timeout");
      vid_req = 0; cpu_req = 0;
    end
    @(posedge clk_sys); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_cpu_ack"}, {31'd0, cpu_ack}, 32'd0);
    chk({tag, "_vid_valid"}, {31'd0, vid_valid}, 32'd0);
    chk({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
    chk({tag, "_vid_dout1"}, {16'd0, vid_dout1}, 32'd0);
    chk({tag, "_vid_dout2"}, {16'd0, vid_dout2}, 32'd0);
    chk({tag, "_cpu_dout"}, {24'd0, cpu_dout}, 32'd0);
  endtask

  initial begin
    int n;
    reset = 1; vid_req = 0; cpu_req = 0; cpu_we = 0;
    vid_addr1 = 0; vid_addr2 = 0; cpu_addr = 0; cpu_din = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_idle_outputs("reset");
    reset = 0;
    repeat (2) @(posedge clk_sys);
    #1;

    // Video pair fetch with a 2-cycle memory
    lat = 2;
    do_txn(1, 0, 19'h00100, 19'h06100, 20'd0, 0, 8'd0, 0);

    // CPU read of an odd byte issued at phase 0
    n = 0;
    while (!(hc_phase == 3'd0 && ce_6mn == 1'b0) && n < 100) begin
      @(negedge clk_sys); n++;
    end
    @(posedge clk_sys); #1;
    do_txn(0, 1, 19'd0, 19'd0, 20'h00201, 0, 8'd0, 0);

    // Video and CPU raised together
    lat = 1;
    do_txn(1, 1, 19'h00003, 19'h00004, 20'h00007, 0, 8'd0, 0);

    // CPU write to an even byte
    do_txn(0, 1, 19'd0, 19'd0, 20'h00010, 1, 8'hA5, 0);

    // Randomized mix over a small address pool so reads see earlier writes
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      lat = $urandom_range(0, 4);
      do_txn(kind != 1, kind != 0, 19'($urandom_range(0, 31)), 19'($urandom_range(0, 31)),
             20'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 8'($urandom), 0);
      repeat ($urandom_range(0, 5)) @(posedge clk_sys);
      #1;
    end

    // Watchdog abort of a CPU read that never gets an ack
    block_en = 1; block_addr = 19'h00020;
    do_txn(0, 1, 19'd0, 19'd0, 20'h00040, 0, 8'd0, 1);
    chk("timeout_req_len", last_len, TIMEOUT_CYC);
    chk("timeout_err", {31'd0, err_timeout}, 32'd1);
    chk("timeout_mem_req", {31'd0, mem_req}, 32'd0);
    block_en = 0;
    lat = 1;
    do_txn(0, 1, 19'd0, 19'd0, 20'h00041, 0, 8'd0, 0);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset while the second video word is outstanding, then a stray ack
    block_en = 1; block_addr = 19'h00031;
    push_acc(19'h00030, 1'b0, 2'b11, 16'd0, 0);
    vid_addr1 = 19'h00030; vid_addr2 = 19'h00031; vid_req = 1;
    n = 0;
    while (!(mem_req && mem_addr == 19'h00031) && n < 200) begin
      @(posedge clk_sys); #1; n++;
    end
    if (n >= 200) fail_now("reach_vid2");
    reset = 1; vid_req = 0;
    @(posedge clk_sys); #1;
    check_idle_outputs("midreset");
    reset = 0;
    force_ack = 1;
    repeat (10) @(posedge clk_sys);
    #1;
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    block_en = 0;

    chk("acc_q_empty", acc_q.size(), 32'd0);
    chk("vid_q_empty", vid_q.size(), 32'd0);
    chk("cpu_q_empty", cpu_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
